image_sequencer: RTL and testbench

IMAGE_SEQUENCER -- requirements
Module: image_sequencer

---
 rtl/image_seq_pkg.sv | 35 +++
 rtl/image_sequencer_if.sv | 26 ++
 rtl/image_sequencer.sv | 112 +++++++++++
 tb/tb_image_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/image_seq_pkg.sv
// Shared types and constants for the image sequencer: FSM states, status
// encodings presented to the processor, and default frame geometry.
package image_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_PROC,
    S_RADDR,
    S_RWAIT,
    S_ROUT,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_PROC = 2'b01;
  localparam logic [1:0] ST_READ = 2'b11;

  localparam int unsigned  DEF_IN_PIXELS  = 16384;
  localparam logic [15:0]  DEF_OUT_BASE   = 16'h4000;
  localparam int unsigned  DEF_OUT_PIXELS = 4096;
  localparam int unsigned  DEF_RD_LAT     = 2;

  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      S_LOAD, S_FLUSH:          status_of = ST_LOAD;
      S_PROC:                   status_of = ST_PROC;
      S_RADDR, S_RWAIT, S_ROUT: status_of = ST_READ;
      default:                  status_of = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/image_sequencer_if.sv
// Bundle of the sequencer's stream, processor-control and data-memory signals.
// master = the sequencer itself, slave = the surrounding system.
interface image_sequencer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [1:0]  status;
  logic [7:0]  data_in;
  logic [15:0] data_addr_in;
  logic        end_process;
  logic [7:0]  dm_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        done;

  modport master (
    input  in_valid, in_data, end_process, dm_out, out_ready,
    output in_ready, status, data_in, data_addr_in, out_valid, out_data, done
  );

  modport slave (
    output in_valid, in_data, end_process, dm_out, out_ready,
    input  in_ready, status, data_in, data_addr_in, out_valid, out_data, done
  );
endinterface

// File: rtl/image_sequencer.sv
// Streams an image into processor data memory, waits for the processor to
// finish, then reads the downsampled result back out as a byte stream.
module image_sequencer
  import image_seq_pkg::*;
#(
  parameter int unsigned IN_PIXELS  = DEF_IN_PIXELS,
  parameter logic [15:0] OUT_BASE   = DEF_OUT_BASE,
  parameter int unsigned OUT_PIXELS = DEF_OUT_PIXELS,
  parameter int unsigned RD_LAT     = DEF_RD_LAT
) (
  input logic              clk,
  input logic              rst,
  image_sequencer_if.master bus
);

  localparam logic [16:0] LAST_IN  = 17'(IN_PIXELS - 1);
  localparam logic [16:0] LAST_OUT = 17'(OUT_PIXELS - 1);
  localparam logic [7:0]  LAST_DLY = 8'(RD_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [16:0] r_load_cnt;
  logic [16:0] r_rd_cnt;
  logic [7:0]  r_dly;
  logic [7:0]  r_data_in;
  logic [15:0] r_addr;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        w_accept;

  assign bus.in_ready     = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept         = bus.in_valid && bus.in_ready;
  assign bus.status       = status_of(r_state);
  assign bus.done         = (r_state == S_DONE);
  assign bus.data_in      = r_data_in;
  assign bus.data_addr_in = r_addr;
  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_LOAD: if (w_accept) w_next = (r_load_cnt == LAST_IN) ? S_FLUSH : S_LOAD;
      S_FLUSH:        w_next = S_PROC;
      S_PROC:         if (bus.end_process) w_next = S_RADDR;
      S_RADDR:        w_next = S_RWAIT;
      S_RWAIT:        if (r_dly == LAST_DLY) w_next = S_ROUT;
      S_ROUT:         if (bus.out_ready) w_next = (r_rd_cnt == LAST_OUT) ? S_DONE : S_RADDR;
      S_DONE:         if (bus.in_valid) w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_dly       <= '0;
      r_data_in   <= '0;
      r_addr      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            r_data_in  <= bus.in_data;
            r_addr     <= r_load_cnt[15:0];
            r_load_cnt <= r_load_cnt + 17'd1;
          end
        end
        S_PROC: begin
          // Present the first readout address together with the status change.
          if (bus.end_process) begin
            r_rd_cnt <= '0;
            r_addr   <= OUT_BASE;
          end
        end
        S_RADDR: begin
          r_addr <= OUT_BASE + r_rd_cnt[15:0];
          r_dly  <= '0;
        end
        S_RWAIT: begin
          r_dly <= r_dly + 8'd1;
          if (r_dly == LAST_DLY) begin
            r_out_data  <= bus.dm_out;
            r_out_valid <= 1'b1;
          end
        end
        S_ROUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_rd_cnt    <= r_rd_cnt + 17'd1;
          end
        end
        S_DONE: begin
          if (bus.in_valid) begin
            r_load_cnt <= '0;
            r_rd_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_sequencer.sv
// Scoreboard bench for image_sequencer: stimulus pushes expected memory-write
// pairs and result bytes; a negedge monitor pops and compares them.
module tb_image_sequencer;
  import image_seq_pkg::*;

  logic clk;
  logic rst;
  logic [7:0] r_dm_q;

  image_sequencer_if bus_if ();

  image_sequencer #(
    .IN_PIXELS (4),
    .OUT_BASE  (16'h4000),
    .OUT_PIXELS(2),
    .RD_LAT    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: returns addr[7:0], valid one edge after the address.
  always_ff @(posedge clk) r_dm_q <= bus_if.data_addr_in[7:0];
  assign bus_if.dm_out = r_dm_q;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_pairs[$];
  logic [7:0]  exp_out[$];
  int unsigned exp_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: new (addr,data) pair while status is LOAD, and every result byte.
  logic        m_prev_load = 1'b0;
  logic [23:0] m_prev_pair = '0;
  always @(negedge clk) begin
    logic [23:0] cur;
    logic [23:0] e;
    if (rst) begin
      m_prev_load = 1'b0;
    end else begin
      cur = {bus_if.data_addr_in, bus_if.data_in};
      if (bus_if.status == ST_LOAD) begin
        if (!m_prev_load || cur != m_prev_pair) begin
          if (exp_pairs.size() == 0) check("unexpected_pair", 32'(cur), 32'hFFFF_FFFF);
          else begin
            e = exp_pairs.pop_front();
            check("load_pair", 32'(cur), 32'(e));
          end
        end
        m_prev_load = 1'b1;
        m_prev_pair = cur;
      end else begin
        m_prev_load = 1'b0;
      end
      if (bus_if.out_valid) begin
        if (exp_out.size() == 0) check("unexpected_out", 32'(bus_if.out_data), 32'hFFFF_FFFF);
        else begin
          check("out_data", 32'(bus_if.out_data), 32'(exp_out[0]));
          if (bus_if.out_ready) void'(exp_out.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = b;
    exp_pairs.push_back({exp_addr[15:0], b});
    exp_addr++;
    step();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (bus_if.done) break;
      step();
    end
    check("done_reached", 32'(bus_if.done), 32'd1);
  endtask

  task automatic readout(input logic hold);
    exp_out.push_back(8'h00);
    exp_out.push_back(8'h01);
    bus_if.out_ready   = ~hold;
    bus_if.end_process = 1'b1;
    step();
    bus_if.end_process = 1'b0;
    check("read_status", 32'(bus_if.status), 32'(ST_READ));
    check("read_addr0", 32'(bus_if.data_addr_in), 32'h4000);
    if (hold) begin
      repeat (5) step();
      check("hold_valid", 32'(bus_if.out_valid), 32'd1);
      check("hold_data", 32'(bus_if.out_data), 32'h00);
      bus_if.out_ready = 1'b1;
    end
    wait_done();
    check("done_status", 32'(bus_if.status), 32'(ST_IDLE));
    check("done_in_ready", 32'(bus_if.in_ready), 32'd0);
  endtask

  task automatic restart_from_done();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'hEE;
    step();
    bus_if.in_valid = 1'b0;
    check("restart_done", 32'(bus_if.done), 32'd0);
    check("restart_status", 32'(bus_if.status), 32'(ST_IDLE));
    check("restart_in_ready", 32'(bus_if.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_status"}, 32'(bus_if.status), 32'(ST_IDLE));
    check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    check({tag, "_data_in"}, 32'(bus_if.data_in), 32'd0);
    check({tag, "_addr"}, 32'(bus_if.data_addr_in), 32'd0);
    check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(bus_if.out_data), 32'd0);
    check({tag, "_done"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus_if.in_valid    = 1'b0;
    bus_if.in_data     = '0;
    bus_if.end_process = 1'b0;
    bus_if.out_ready   = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    step();
    rst = 1'b0;

    // Frame 1: back-to-back load, end_process pulsed mid-load, held readout
    exp_addr = 0;
    send(8'd11);
    bus_if.end_process = 1'b1;
    send(8'd22);
    bus_if.end_process = 1'b0;
    send(8'd33);
    send(8'd44);
    bus_if.in_valid = 1'b0;
    check("flush_status", 32'(bus_if.status), 32'(ST_LOAD));
    check("flush_addr", 32'(bus_if.data_addr_in), 32'd3);
    check("flush_data", 32'(bus_if.data_in), 32'd44);
    step();
    check("proc_status", 32'(bus_if.status), 32'(ST_PROC));
    step();
    step();
    check("proc_hold_status", 32'(bus_if.status), 32'(ST_PROC));
    readout(1'b1);

    // Frame 2: in_valid toggling, addresses restart at 0
    restart_from_done();
    exp_addr = 0;
    send(8'h55);
    bus_if.in_valid = 1'b0;
    step();
    check("idle_hold_addr", 32'(bus_if.data_addr_in), 32'd0);
    check("idle_hold_data", 32'(bus_if.data_in), 32'h55);
    send(8'h66);
    bus_if.in_valid = 1'b0;
    step();
    send(8'h77);
    bus_if.in_valid = 1'b0;
    step();
    send(8'h88);
    bus_if.in_valid = 1'b0;
    step();
    check("f2_proc_status", 32'(bus_if.status), 32'(ST_PROC));
    readout(1'b0);

    // Frame 3: asynchronous reset after byte 2, then a full reload from 0
    restart_from_done();
    exp_addr = 0;
    send(8'hA1);
    send(8'hA2);
    bus_if.in_valid = 1'b0;
    #6 rst = 1'b1;
    #1 check_reset_outputs("async");
    step();
    rst = 1'b0;
    exp_addr = 0;
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    send(8'hC4);
    bus_if.in_valid = 1'b0;
    step();
    check("f3_proc_status", 32'(bus_if.status), 32'(ST_PROC));
    readout(1'b0);

    step();
    check("pairs_drained", 32'(exp_pairs.size()), 32'd0);
    check("out_drained", 32'(exp_out.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
